// File: rtl/fpga_mem_responder.sv
// Line-oriented memory responder: accepts 3-flit request headers on noc2, writes or
// reads one 32-word line of internal RAM, and answers with an ack or a full line on noc3.

`ifndef MSG_LENGTH
`define MSG_LENGTH 29:22
`endif
`ifndef MSG_ADDR_
`define MSG_ADDR_ 39:0
`endif

module fpga_mem_responder #(
    parameter int NOC_DATA_WIDTH = 64,
    parameter int LINES_LOG      = 6,
    parameter int WORDS_PER_LINE = 32,
    parameter int MSG_TAG_HI     = 11,
    parameter int MSG_TAG_LO     = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      noc2_in_val,
    input  logic [NOC_DATA_WIDTH-1:0] noc2_in_data,
    output logic                      noc2_in_rdy,
    output logic                      noc3_out_val,
    output logic [NOC_DATA_WIDTH-1:0] noc3_out_data,
    input  logic                      noc3_out_rdy
);

    localparam int         WORD_BITS   = $clog2(WORDS_PER_LINE);
    localparam int         RAM_AW      = LINES_LOG + WORD_BITS;
    localparam int         TAG_W       = MSG_TAG_HI - MSG_TAG_LO + 1;
    localparam int         LINE_OFFSET = 8;
    localparam logic [5:0] LAST_WORD   = 6'(WORDS_PER_LINE - 1);
    localparam logic [7:0] LINE_LEN    = 8'(WORDS_PER_LINE);

    typedef enum logic [2:0] {
        IDLE, HDR2, HDR3, WR_DATA, WR_DRAIN, WR_ACK, RD_HDR, RD_DATA
    } state_t;

    state_t                    state_reg;
    logic                      rdy_reg;
    logic                      val_reg;
    logic [NOC_DATA_WIDTH-1:0] resp_reg;
    logic [5:0]                word_cnt_reg;
    logic [7:0]                len_reg;
    logic [TAG_W-1:0]          tag_reg;
    logic [`MSG_ADDR_]         addr_reg;

    logic [NOC_DATA_WIDTH-1:0] mem [0:(2**RAM_AW)-1];
    logic [NOC_DATA_WIDTH-1:0] ram_q;

    logic                 in_fire;
    logic                 out_fire;
    logic                 last_word;
    logic                 is_read;
    logic [LINES_LOG-1:0] line_idx;
    logic [5:0]           rd_word;
    logic                 ram_we;
    logic                 ram_re;
    logic [RAM_AW-1:0]    ram_waddr;
    logic [RAM_AW-1:0]    ram_raddr;
    logic                 unused_bits;

    function automatic logic [NOC_DATA_WIDTH-1:0] make_hdr(input logic [7:0]       len,
                                                            input logic [TAG_W-1:0] tag);
        logic [NOC_DATA_WIDTH-1:0] h;
        h                         = '0;
        h[`MSG_LENGTH]            = len;
        h[MSG_TAG_HI:MSG_TAG_LO]  = tag;
        return h;
    endfunction

    assign in_fire   = noc2_in_val & rdy_reg;
    assign out_fire  = val_reg & noc3_out_rdy;
    assign last_word = (word_cnt_reg == LAST_WORD);
    assign is_read   = (len_reg <= 8'd3);
    assign line_idx  = addr_reg[LINE_OFFSET +: LINES_LOG];

    // Reads are fetched one word ahead: word 0 when header 3 is taken, word k+1 when word k leaves.
    assign rd_word   = (state_reg == RD_DATA) ? (word_cnt_reg + 6'd1) : 6'd0;
    assign ram_we    = rst && (state_reg == WR_DATA) && in_fire;
    assign ram_re    = rst && (((state_reg == HDR3) && in_fire && is_read) ||
                               ((state_reg == RD_DATA) && out_fire && !last_word));
    assign ram_waddr = {line_idx, word_cnt_reg[WORD_BITS-1:0]};
    assign ram_raddr = {line_idx, rd_word[WORD_BITS-1:0]};

    assign unused_bits = ^{noc2_in_data, addr_reg, rd_word};

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= noc2_in_data;
        end
        if (ram_re) begin
            ram_q <= mem[ram_raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            rdy_reg      <= 1'b0;
            val_reg      <= 1'b0;
            resp_reg     <= '0;
            word_cnt_reg <= '0;
            len_reg      <= '0;
            tag_reg      <= '0;
            addr_reg     <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    rdy_reg      <= 1'b1;
                    word_cnt_reg <= '0;
                    if (in_fire) begin
                        len_reg   <= noc2_in_data[`MSG_LENGTH];
                        tag_reg   <= noc2_in_data[MSG_TAG_HI:MSG_TAG_LO];
                        state_reg <= HDR2;
                    end
                end
                HDR2: begin
                    if (in_fire) begin
                        addr_reg  <= noc2_in_data[`MSG_ADDR_];
                        state_reg <= HDR3;
                    end
                end
                HDR3: begin
                    if (in_fire) begin
                        if (is_read) begin
                            state_reg <= RD_HDR;
                            rdy_reg   <= 1'b0;
                            val_reg   <= 1'b1;
                            resp_reg  <= make_hdr(LINE_LEN, tag_reg);
                        end else begin
                            // len_reg now counts the data flits still to come
                            len_reg   <= len_reg - 8'd2;
                            state_reg <= WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (in_fire) begin
                        word_cnt_reg <= word_cnt_reg + 6'd1;
                        len_reg      <= len_reg - 8'd1;
                        if (len_reg == 8'd1) begin
                            state_reg <= WR_ACK;
                            rdy_reg   <= 1'b0;
                            val_reg   <= 1'b1;
                            resp_reg  <= make_hdr(8'd0, tag_reg);
                        end else if (last_word) begin
                            state_reg <= WR_DRAIN;
                        end
                    end
                end
                WR_DRAIN: begin
                    if (in_fire) begin
                        len_reg <= len_reg - 8'd1;
                        if (len_reg == 8'd1) begin
                            state_reg <= WR_ACK;
                            rdy_reg   <= 1'b0;
                            val_reg   <= 1'b1;
                            resp_reg  <= make_hdr(8'd0, tag_reg);
                        end
                    end
                end
                WR_ACK: begin
                    if (out_fire) begin
                        state_reg    <= IDLE;
                        rdy_reg      <= 1'b1;
                        val_reg      <= 1'b0;
                        resp_reg     <= '0;
                        word_cnt_reg <= '0;
                    end
                end
                RD_HDR: begin
                    if (out_fire) begin
                        state_reg <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (out_fire) begin
                        if (last_word) begin
                            state_reg    <= IDLE;
                            rdy_reg      <= 1'b1;
                            val_reg      <= 1'b0;
                            resp_reg     <= '0;
                            word_cnt_reg <= '0;
                        end else begin
                            word_cnt_reg <= word_cnt_reg + 6'd1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    rdy_reg   <= 1'b0;
                    val_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign noc2_in_rdy   = rdy_reg;
    assign noc3_out_val  = val_reg;
    assign noc3_out_data = (state_reg == RD_DATA) ? ram_q : resp_reg;

endmodule

// File: tb/tb_fpga_mem_responder.sv
// Directed bench for fpga_mem_responder: write/read, backpressure, short, wrapped,
// overlong writes and a reset in the middle of a read response.

module tb_fpga_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        noc2_in_val = 1'b0;
    logic [63:0] noc2_in_data = '0;
    logic        noc2_in_rdy;
    logic        noc3_out_val;
    logic [63:0] noc3_out_data;
    logic        noc3_out_rdy = 1'b0;

    fpga_mem_responder dut (
        .clk           (clk),
        .rst           (rst),
        .noc2_in_val   (noc2_in_val),
        .noc2_in_data  (noc2_in_data),
        .noc2_in_rdy   (noc2_in_rdy),
        .noc3_out_val  (noc3_out_val),
        .noc3_out_data (noc3_out_data),
        .noc3_out_rdy  (noc3_out_rdy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int last_in_cyc = 0;
    int resp_first = 0;
    int resp_last = 0;

    logic [63:0] wdata [0:33];
    logic [63:0] exp_q [0:32];
    logic [63:0] model [0:63][0:31];

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [7:0] len, input logic [5:0] tag);
        logic [63:0] h;
        h        = '0;
        h[29:22] = len;
        h[11:6]  = tag;
        return h;
    endfunction

    // Entered just after a rising edge; returns just after the edge that took the flit.
    task automatic send(input logic [63:0] d);
        int n = 0;
        noc2_in_val  = 1'b1;
        noc2_in_data = d;
        @(negedge clk);
        while (!noc2_in_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!noc2_in_rdy) chk("send_rdy_timeout", {63'b0, noc2_in_rdy}, 64'd1);
        @(posedge clk);
        #1;
        last_in_cyc = cyc;
    endtask

    task automatic write_pkt(input logic [5:0] tag, input logic [63:0] addr,
                             input logic [7:0] len, input int ndata);
        send(hdr(len, tag));
        send(addr);
        send(64'h0);
        for (int k = 0; k < ndata; k++) send(wdata[k]);
        noc2_in_val  = 1'b0;
        noc2_in_data = '0;
        for (int k = 0; k < ndata && k < 32; k++) model[addr[13:8]][k] = wdata[k];
        exp_q[0] = hdr(8'd0, tag);
        $display("write tag=%h addr=%h len=%0d data_flits=%0d last_flit_cycle=%0d",
                 tag, addr, len, ndata, last_in_cyc);
    endtask

    task automatic read_pkt(input logic [5:0] tag, input logic [63:0] addr);
        send(hdr(8'd3, tag));
        send(addr);
        send(64'h0);
        noc2_in_val  = 1'b0;
        noc2_in_data = '0;
        exp_q[0] = hdr(8'd32, tag);
        for (int k = 0; k < 32; k++) exp_q[k+1] = model[addr[13:8]][k];
        $display("read  tag=%h addr=%h hdr3_cycle=%0d", tag, addr, last_in_cyc);
    endtask

    // Accepts n response flits, optionally toggling rdy, and checks order and stall stability.
    task automatic collect(input string name, input int n, input bit toggle, input bit check_end);
        int          k = 0;
        int          t = 0;
        bit          held = 1'b0;
        logic [63:0] hold_data = '0;
        while (k < n && t < 400) begin
            @(negedge clk);
            t++;
            noc3_out_rdy = toggle ? cyc[0] : 1'b1;
            if (held) begin
                chk($sformatf("%s_hold_val_%0d", name, k), {63'b0, noc3_out_val}, 64'd1);
                chk($sformatf("%s_hold_data_%0d", name, k), noc3_out_data, hold_data);
                held = 1'b0;
            end
            if (noc3_out_val && noc3_out_rdy) begin
                chk($sformatf("%s_flit_%0d", name, k), noc3_out_data, exp_q[k]);
                if (k == 0) resp_first = cyc + 1;
                resp_last = cyc + 1;
                k++;
            end else if (noc3_out_val) begin
                held      = 1'b1;
                hold_data = noc3_out_data;
            end
        end
        chk($sformatf("%s_count", name), 64'(k), 64'(n));
        @(posedge clk);
        #1;
        noc3_out_rdy = 1'b0;
        if (check_end) chk($sformatf("%s_end_val", name), {63'b0, noc3_out_val}, 64'd0);
        $display("resp  %s flits=%0d first_cycle=%0d last_cycle=%0d", name, k, resp_first, resp_last);
    endtask

    initial begin
        int t0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", {63'b0, noc2_in_rdy}, 64'd0);
        chk("rst_val", {63'b0, noc3_out_val}, 64'd0);
        chk("rst_data", noc3_out_data, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_rdy", {63'b0, noc2_in_rdy}, 64'd1);

        // Full-line write then read back
        for (int k = 0; k < 34; k++) wdata[k] = 64'(k + 1);
        write_pkt(6'h15, 64'h100, 8'd34, 32);
        t0 = last_in_cyc;
        chk("ack1_value", exp_q[0], 64'h540);
        collect("ack1", 1, 1'b0, 1'b1);
        chk("ack1_time", 64'(resp_first), 64'(t0 + 1));

        read_pkt(6'h15, 64'h100);
        t0 = last_in_cyc;
        chk("rd1_rdy_low", {63'b0, noc2_in_rdy}, 64'd0);
        chk("rd1_hdr_value", exp_q[0], 64'h0800_0540);
        chk("rd1_word31_value", exp_q[32], 64'd32);
        collect("rd1", 33, 1'b0, 1'b1);
        chk("rd1_hdr_time", 64'(resp_first), 64'(t0 + 1));
        chk("rd1_last_time", 64'(resp_last), 64'(t0 + 33));

        // Read with rdy toggling every cycle
        read_pkt(6'h2A, 64'h100);
        collect("rdbp", 33, 1'b1, 1'b1);

        // Short write over preloaded line
        wdata[0] = 64'hA;
        wdata[1] = 64'hB;
        wdata[2] = 64'hC;
        write_pkt(6'h03, 64'h100, 8'd5, 3);
        t0 = last_in_cyc;
        collect("ack_short", 1, 1'b0, 1'b1);
        chk("ack_short_time", 64'(resp_first), 64'(t0 + 1));
        read_pkt(6'h03, 64'h100);
        chk("short_w2_value", exp_q[3], 64'hC);
        chk("short_w3_value", exp_q[4], 64'd4);
        collect("rd_short", 33, 1'b0, 1'b1);

        // Address wrap: 0x4100 and 0x100 hit the same line
        for (int k = 0; k < 32; k++) wdata[k] = 64'hC0DE_0000_0000_0000 | 64'(k);
        write_pkt(6'h07, 64'h4100, 8'd34, 32);
        collect("ack_wrap", 1, 1'b0, 1'b1);
        read_pkt(6'h08, 64'h100);
        chk("wrap_w5_value", exp_q[6], 64'hC0DE_0000_0000_0005);
        collect("rd_wrap", 33, 1'b0, 1'b1);

        // Overlong write: 34 data flits, only 32 stored
        for (int k = 0; k < 34; k++) wdata[k] = 64'h5000 + 64'(k);
        write_pkt(6'h3F, 64'h200, 8'd36, 34);
        t0 = last_in_cyc;
        collect("ack_long", 1, 1'b0, 1'b1);
        chk("ack_long_time", 64'(resp_first), 64'(t0 + 1));
        read_pkt(6'h11, 64'h200);
        chk("long_w31_value", exp_q[32], 64'h501F);
        collect("rd_long", 33, 1'b0, 1'b1);

        // Reset in the middle of a read response
        read_pkt(6'h12, 64'h200);
        collect("rd_cut", 11, 1'b0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_val", {63'b0, noc3_out_val}, 64'd0);
        chk("midrst_rdy", {63'b0, noc2_in_rdy}, 64'd0);
        chk("midrst_data", noc3_out_data, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_rdy_back", {63'b0, noc2_in_rdy}, 64'd1);
        read_pkt(6'h13, 64'h200);
        collect("rd_after_rst", 33, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
